// File: rtl/ss_d2a.sv
// ---------------------------------------------------------------------------
// ss_d2a -- single-slope D2A (ramp-compare PWM generator)
//
// Turns a WIDTH-bit code into a PWM stream for an external RC filter. A free
// running ramp counter is compared against the active code, so the output is
// high for exactly <code> clocks of every 2^WIDTH-clock frame. A conversion
// replays the code for NUM_FRM frames and then pulses cnv_cmplt for one clock.
// Codes written while a conversion runs are parked in a shadow register and
// only take effect at a frame boundary, so no frame ever mixes two codes.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   strt_cnv   in   start conversion / load a new code
//   val        in   code to convert, sampled only with strt_cnv
//   pwm        out  registered PWM output
//   busy       out  high while the controller is converting
//   cnv_cmplt  out  registered one-clock pulse at the end of a conversion
// ---------------------------------------------------------------------------
// state | meaning
// ------+--------------------------------------------------------------------
// IDLE  | pwm held low, counters parked at 0, waiting for strt_cnv
// RUN   | ramp counter running, pwm = (cnt < hold), frames counted
// ---------------------------------------------------------------------------
module ss_d2a #(
  parameter int WIDTH   = 10,
  parameter int NUM_FRM = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strt_cnv,
  input  logic [WIDTH-1:0] val,
  output logic             pwm,
  output logic             busy,
  output logic             cnv_cmplt
);

  localparam int FRM_W = (NUM_FRM > 1) ? $clog2(NUM_FRM) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [WIDTH-1:0] CNT_LAST = {WIDTH{1'b1}};
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(NUM_FRM - 1);

  logic [0:0]       state_q,  state_d;
  logic [WIDTH-1:0] hold_q,   hold_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pend_q,   pend_d;
  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [FRM_W-1:0] frm_q,    frm_d;
  logic             pwm_q,    pwm_d;
  logic             cmplt_q,  cmplt_d;

  logic boundary;

  // Last slot of the current frame: the only cycle in which hold may change.
  assign boundary = (state_q == S_RUN) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    frm_d    = frm_q;
    pwm_d    = 1'b0;
    cmplt_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        frm_d = '0;
        if (strt_cnv) begin
          hold_d  = val;
          pend_d  = 1'b0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + WIDTH'(1);
        // Uses the code that owns this frame, including in the boundary
        // cycle, so the final slot of every frame is still the old code.
        pwm_d = (cnt_q < hold_q);

        if (boundary) begin
          if (strt_cnv) begin
            // A write landing exactly on the boundary beats any pending one.
            hold_d = val;
            pend_d = 1'b0;
            frm_d  = '0;
          end else if (pend_q) begin
            // New code restarts the conversion so it also gets NUM_FRM frames.
            hold_d = shadow_q;
            pend_d = 1'b0;
            frm_d  = '0;
          end else if (frm_q != FRM_LAST) begin
            frm_d = frm_q + FRM_W'(1);
          end else begin
            frm_d   = '0;
            state_d = S_IDLE;
            cmplt_d = 1'b1;
          end
        end else if (strt_cnv) begin
          // Mid-frame write: park it; the latest write before a boundary wins.
          shadow_d = val;
          pend_d   = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      frm_q    <= '0;
      pwm_q    <= 1'b0;
      cmplt_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      frm_q    <= frm_d;
      pwm_q    <= pwm_d;
      cmplt_q  <= cmplt_d;
    end
  end

  assign pwm       = pwm_q;
  assign busy      = (state_q == S_RUN);
  assign cnv_cmplt = cmplt_q;

endmodule

// File: tb/tb_ss_d2a.sv
// Directed bench for ss_d2a. Expected per-frame high counts are queued when a
// code is driven and popped as each PWM frame completes on the output.
module tb_ss_d2a;

  localparam int W    = 10;
  localparam int NFRM = 8;
  localparam int FLEN = 1 << W;
  localparam int CONV = NFRM * FLEN;

  logic         clk;
  logic         rst;
  logic         strt_cnv;
  logic [W-1:0] val;
  logic         pwm;
  logic         busy;
  logic         cnv_cmplt;

  ss_d2a #(.WIDTH(W), .NUM_FRM(NFRM)) dut (
    .clk       (clk),
    .rst       (rst),
    .strt_cnv  (strt_cnv),
    .val       (val),
    .pwm       (pwm),
    .busy      (busy),
    .cnv_cmplt (cnv_cmplt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int exp_q[$];

  // Monitor state, relative to the edge E0 that sampled the start.
  bit active    = 1'b0;
  int rel       = 0;
  int frame_hi  = 0;
  int total_hi  = 0;
  int busy_cnt  = 0;
  int cmplt_cnt = 0;
  int cmplt_rel = -1;

  task automatic check(input string tag, input int obs, input int expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Advance to the next falling edge (cycle E0+rel) and accumulate output.
  task automatic tick();
    int e;
    @(negedge clk);
    if (active) begin
      rel++;
      if (busy) busy_cnt++;
      if (cnv_cmplt) begin
        cmplt_cnt++;
        cmplt_rel = rel;
      end
      if (rel >= 2) begin
        frame_hi += int'(pwm);
        total_hi += int'(pwm);
        if ((rel - 2) % FLEN == FLEN - 1) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_hi", frame_hi, e);
          end
          frame_hi = 0;
        end
      end
    end
  endtask

  task automatic push_n(input int n, input int v);
    repeat (n) exp_q.push_back(v);
  endtask

  task automatic run_to(input int r);
    while (rel < r) tick();
  endtask

  // Drive strt_cnv so the coming rising edge is E0; returns in cycle E0+1.
  task automatic start(input int v);
    strt_cnv  = 1'b1;
    val       = W'(v);
    active    = 1'b1;
    rel       = 0;
    frame_hi  = 0;
    total_hi  = 0;
    busy_cnt  = 0;
    cmplt_cnt = 0;
    cmplt_rel = -1;
    tick();
    strt_cnv = 1'b0;
  endtask

  // Write a code in cycle E0+r (sampled at the edge ending that cycle).
  task automatic write_at(input int r, input int v);
    run_to(r);
    strt_cnv = 1'b1;
    val      = W'(v);
    tick();
    strt_cnv = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    strt_cnv = 1'b0;
    val      = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Quiet after reset
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_quiet", int'({pwm, busy, cnv_cmplt}), 0);
    end

    // Code 256, single start
    push_n(NFRM, 256);
    start(256);
    check("busy_rise", int'(busy), 1);
    check("pwm_first", int'(pwm), 0);
    run_to(CONV + 1);
    check("c256_cmplt_cnt", cmplt_cnt, 1);
    check("c256_cmplt_at", cmplt_rel, CONV + 1);
    check("c256_busy_len", busy_cnt, CONV);
    check("c256_total_hi", total_hi, 2048);
    check("c256_busy_end", int'(busy), 0);
    check("c256_sb_empty", exp_q.size(), 0);

    // Code 0, started in the cnv_cmplt cycle (no gap)
    push_n(NFRM, 0);
    start(0);
    check("b2b_busy", int'(busy), 1);
    run_to(CONV + 1);
    check("c0_cmplt_cnt", cmplt_cnt, 1);
    check("c0_cmplt_at", cmplt_rel, CONV + 1);
    check("c0_total_hi", total_hi, 0);
    check("c0_sb_empty", exp_q.size(), 0);

    // Code 1023: one low clock per frame
    tick();
    push_n(NFRM, 1023);
    start(1023);
    run_to(CONV + 1);
    check("c1023_cmplt_at", cmplt_rel, CONV + 1);
    check("c1023_total_lo", CONV - total_hi, NFRM);
    check("c1023_sb_empty", exp_q.size(), 0);

    // 100, then 900 written in frame 3 at cnt=500
    tick();
    push_n(4, 100);
    push_n(NFRM, 900);
    start(100);
    write_at(1 + 3 * FLEN + 500, 900);
    run_to(1 + 12 * FLEN);
    check("mid_cmplt_cnt", cmplt_cnt, 1);
    check("mid_cmplt_at", cmplt_rel, 1 + 12 * FLEN);
    check("mid_busy_len", busy_cnt, 12 * FLEN);
    check("mid_sb_empty", exp_q.size(), 0);

    // Pending 7 superseded by boundary write of 5; then 7, 9 in one frame
    tick();
    push_n(2, 300);
    push_n(1, 5);
    push_n(NFRM, 9);
    start(300);
    write_at(1500, 7);
    write_at(2 * FLEN, 5);
    write_at(2500, 7);
    write_at(2700, 9);
    run_to(1 + 11 * FLEN);
    check("bnd_cmplt_cnt", cmplt_cnt, 1);
    check("bnd_cmplt_at", cmplt_rel, 1 + 11 * FLEN);
    check("bnd_sb_empty", exp_q.size(), 0);

    // Reset in frame 4
    tick();
    push_n(4, 256);
    start(256);
    run_to(1 + 4 * FLEN + 300);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_pwm", int'(pwm), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sb_empty", exp_q.size(), 0);
    repeat (CONV + 500) tick();
    check("rst_no_cmplt", cmplt_cnt, 0);
    check("rst_busy_len", busy_cnt, 1 + 4 * FLEN + 300);

    // Fresh conversion after the abort
    push_n(NFRM, 256);
    start(256);
    run_to(CONV + 1);
    check("post_cmplt_cnt", cmplt_cnt, 1);
    check("post_cmplt_at", cmplt_rel, CONV + 1);
    check("post_busy_len", busy_cnt, CONV);
    check("post_total_hi", total_hi, 2048);
    check("post_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ss_d2a.md
# ss_D2A

Single-slope digital-to-analog converter: the output-side counterpart of the single-slope A2D. It turns a 10-bit code into a ramp-compare PWM stream that drives the external RC filter. Each conversion replays the code for NUM_FRM consecutive frames, mirroring the A2D's 8-sample averaging, then pulses `cnv_cmplt`. A new code written mid-conversion is double-buffered and applied cleanly at the next frame boundary.

## Interface
- `WIDTH`, 10: code width; frame length is 2^WIDTH clocks.
- `NUM_FRM`, 8: frames per conversion; power of 2, at least 2.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `strt_cnv`  in  1  start conversion / load code; sampled every clock.
- `val`  in  WIDTH  code to convert; sampled only when `strt_cnv` is 1.
- `pwm`  out  1  registered PWM output to the RC filter.
- `busy`  out  1  1 while the state machine is in RUN.
- `cnv_cmplt`  out  1  registered one-clock pulse when a conversion finishes.

## Operation
- Internal state:
  - `hold`: active code, WIDTH bits.
  - `shadow`: pending code, WIDTH bits.
  - `pend`: flag, 1 bit.
  - `cnt`: ramp counter, WIDTH bits, wraps.
  - `frm`: frame counter, log2(NUM_FRM) bits.
  - State machine with two states, IDLE and RUN.
- Reset (`rst`=1 at an edge):
  - state goes to IDLE; `hold`, `shadow`, `pend`, `cnt`, `frm` all clear to 0.
  - `pwm`=0, `busy`=0, `cnv_cmplt`=0 from the following cycle.
  - Reset takes priority over every other input, including mid-RUN; an aborted conversion never produces `cnv_cmplt`.
- IDLE:
  - `pwm`=0, `cnt`/`frm` held at 0.
  - `strt_cnv`=1: `hold`<=`val`, `cnt`<=0, `frm`<=0, `pend`<=0, go to RUN.
- RUN:
  - `cnt` increments every clock, wrapping 2^WIDTH-1 -> 0.
  - `pwm`<=(`cnt` < `hold`), unsigned WIDTH-bit compare. The output is therefore high for exactly `hold` clocks per frame: code 0 gives constant 0, code 2^WIDTH-1 gives 1 low clock per frame.
- `strt_cnv`=1 in RUN, not in the boundary cycle:
  - `shadow`<=`val`, `pend`<=1.
  - If several arrive before a boundary, the last one wins.
- Boundary cycle: RUN with `cnt`=2^WIDTH-1.
  - With `strt_cnv`=1: `hold`<=`val` directly. This bypasses and supersedes `shadow`. Also `pend`<=0, `frm`<=0, stay in RUN.
  - Else with `pend`=1: `hold`<=`shadow`, `pend`<=0, `frm`<=0, stay in RUN. The conversion restarts, so the new code also gets NUM_FRM full frames.
  - Else with `frm`<NUM_FRM-1: `frm`<=`frm`+1, stay in RUN.
  - Else (`frm`=NUM_FRM-1): go to IDLE, `cnv_cmplt`<=1 for one clock.
- A code is never changed mid-frame; every frame `pwm` emits reflects exactly one code.

## Timing
- Let the edge that samples `strt_cnv`=1 in IDLE be edge E0.
- `busy`=1 from the cycle after E0.
  - `cnt`=0 in that cycle; `pwm` shows the first compare result one clock later, at cycle E0+2.
- Frame n (n = 0..NUM_FRM-1) occupies `pwm` cycles E0+2+n·2^WIDTH through E0+1+(n+1)·2^WIDTH.
- For an uninterrupted conversion:
  - `busy` falls and `cnv_cmplt` is 1 in cycle E0+1+NUM_FRM·2^WIDTH.
  - That is the same cycle `pwm` shows the final slot, which is always 0.
- `strt_cnv` sampled in that `cnv_cmplt` cycle (now IDLE) starts a new conversion with no gap cycle.
- A new code written mid-conversion first appears on `pwm` at the start of the next frame, 2 cycles after the boundary edge.

## Test plan
- Reset, then no stimulus for 100 clocks.
  - Required: `pwm`, `busy`, `cnv_cmplt` all 0 throughout.
- `val`=256, single `strt_cnv`; default parameters.
  - Each frame: `pwm` high exactly 256 clocks, then low 768.
  - Conversion total: 2048 high clocks.
  - `cnv_cmplt`: one pulse at E0+8193; `busy` high for 8192 clocks.
- Extreme codes.
  - `val`=0: `pwm` never high; `cnv_cmplt` still at E0+8193.
  - `val`=1023: exactly 1 low clock per frame, 8 in total.
- `val`=100, then `strt_cnv` with `val`=900 during frame 3, cnt=500.
  - Frame 3 finishes at 100 high clocks.
  - The next 8 frames are each 900 high clocks.
  - `cnv_cmplt` at the end of those 8 frames only.
- Boundary-cycle write and back-to-back writes.
  - `strt_cnv` with `val`=5 at cnt=1023: the next frame uses 5.
  - Two writes, 7 then 9, within one frame: the next frame uses 9.
- `rst` asserted mid-frame 4.
  - Next cycle `pwm`=0, `busy`=0.
  - No `cnv_cmplt` ever follows.
  - A fresh `strt_cnv` afterwards behaves as in the second test.
